// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder controller, LSB first, one bit per clock.
// Build option: define SERIAL_ADD_CTRL_CIN_EN to add a carry-in port (cin).
// Ports:
//   clk, rst_n     - clock (rising edge), asynchronous active-low reset
//   start          - begin an addition (accepted only when idle)
//   a, b           - operands, captured when start is accepted
//   cin            - carry-in, captured with start (SERIAL_ADD_CTRL_CIN_EN only)
//   busy           - high while an addition is in progress (RUN and DONE)
//   done           - one-cycle pulse when sum/carry hold a new result
//   sum, carry     - registered result, held until the next result
module serial_add_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADD_CTRL_CIN_EN
  input  logic             cin,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             c_q, c_d, carry_d, busy_d, done_d;
  logic             p, g1, g2, s_bit, c_nx, cin_val;
  logic [WIDTH-1:0] res_nx;

`ifdef SERIAL_ADD_CTRL_CIN_EN
  assign cin_val = cin;
`else
  assign cin_val = 1'b0;
`endif

  // Two cascaded half adders on the current LSBs.
  assign p      = a_q[0] ^ b_q[0];
  assign g1     = a_q[0] & b_q[0];
  assign s_bit  = p ^ c_q;
  assign g2     = p & c_q;
  assign c_nx   = g1 | g2;
  // New sum bit enters at the MSB; after WIDTH shifts bit 0 sits at bit 0.
  assign res_nx = (res_q >> 1) | (WIDTH'(s_bit) << (WIDTH - 1));

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      c_q     <= 1'b0;
      sum     <= '0;
      carry   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      c_q     <= c_d;
      sum     <= sum_d;
      carry   <= carry_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    c_d     = c_q;
    sum_d   = sum;
    carry_d = carry;
    busy_d  = busy;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          a_d     = a;
          b_d     = b;
          cnt_d   = '0;
          c_d     = cin_val;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d    = a_q >> 1;
        b_d    = b_q >> 1;
        res_d  = res_nx;
        c_d    = c_nx;
        cnt_d  = cnt_q + CW'(1);
        busy_d = 1'b1;
        // Last bit: publish the completed result alongside the done pulse.
        if (cnt_q == CW'(WIDTH - 1)) begin
          sum_d   = res_nx;
          carry_d = c_nx;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
module tb_serial_add_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic       cin = 1'b0;
  logic       busy, done, carry;
  logic [7:0] sum;

  logic       start1 = 1'b0;
  logic       a1 = 1'b0, b1 = 1'b0;
  logic       busy1, done1, carry1, sum1;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  serial_add_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
`ifdef SERIAL_ADD_CTRL_CIN_EN
    .cin(cin),
`endif
    .busy(busy), .done(done), .sum(sum), .carry(carry)
  );

  serial_add_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1),
`ifdef SERIAL_ADD_CTRL_CIN_EN
    .cin(1'b0),
`endif
    .busy(busy1), .done(done1), .sum(sum1), .carry(carry1)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] exp_sum;
    logic       exp_carry;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // One addition: accept at edge T, then observe edges T..T+12 on negedges.
  task automatic run_op(input vec_t v, input string tag);
    int lat, busy_cnt, done_cnt, hold_bad;
    logic [7:0] prev_sum, got_sum;
    logic       got_carry;
    lat = -1; busy_cnt = 0; done_cnt = 0; hold_bad = 0;
    got_sum = '0; got_carry = 1'b0;
    @(negedge clk);
    prev_sum = sum;
    a = v.a; b = v.b; cin = v.cin; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k <= 12; k++) begin
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (lat < 0) begin
          lat = k; got_sum = sum; got_carry = carry;
        end
      end
      if (k < 8 && sum !== prev_sum) hold_bad++;
      if (k < 12) @(negedge clk);
    end
    chk({tag, "_latency"}, lat, 8);
    chk({tag, "_busy_cycles"}, busy_cnt, 9);
    chk({tag, "_done_pulses"}, done_cnt, 1);
    chk({tag, "_sum"}, int'(got_sum), int'(v.exp_sum));
    chk({tag, "_carry"}, int'(got_carry), int'(v.exp_carry));
    chk({tag, "_sum_held_in_run"}, hold_bad, 0);
  endtask

  initial begin
    int d_k[$];
    logic [7:0] d_sum[$];
    int lat1, dn;

    vecs.push_back('{8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0});
    vecs.push_back('{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1});
    vecs.push_back('{8'hFF, 8'hFF, 1'b0, 8'hFE, 1'b1});
    vecs.push_back('{8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0});
    vecs.push_back('{8'h80, 8'h80, 1'b0, 8'h00, 1'b1});
    vecs.push_back('{8'h00, 8'h00, 1'b0, 8'h00, 1'b0});
`ifdef SERIAL_ADD_CTRL_CIN_EN
    vecs.push_back('{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1});
    vecs.push_back('{8'h12, 8'h34, 1'b1, 8'h47, 1'b0});
`else
    vecs.push_back('{8'hFF, 8'h00, 1'b1, 8'hFF, 1'b0});
`endif

    // Reset state
    #12;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_sum", int'(sum), 0);
    chk("rst_carry", int'(carry), 0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) run_op(vecs[i], $sformatf("vec%0d", i));

    // Start held high; operands switched right after the first acceptance.
    @(negedge clk);
    a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a = 8'h01; b = 8'h02;
    for (int k = 0; k <= 24; k++) begin
      if (done) begin
        d_k.push_back(k); d_sum.push_back(sum);
      end
      if (k < 24) @(negedge clk);
    end
    start = 1'b0;
    chk("held_done_count", d_k.size(), 2);
    if (d_k.size() == 2) begin
      chk("held_first_latency", d_k[0], 8);
      chk("held_done_spacing", d_k[1] - d_k[0], 10);
      chk("held_sum0", int'(d_sum[0]), 8'h30);
      chk("held_sum1", int'(d_sum[1]), 8'h03);
    end
    repeat (4) @(negedge clk);

    // Reset during RUN cycle 4.
    a = 8'h80; b = 8'h80; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_done", int'(done), 0);
    chk("midrst_sum", int'(sum), 0);
    chk("midrst_carry", int'(carry), 0);
    @(negedge clk);
    rst_n = 1'b1;
    dn = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done || busy) dn++;
    end
    chk("midrst_no_done", dn, 0);
    run_op('{8'h02, 8'h03, 1'b0, 8'h05, 1'b0}, "post_rst");

    // WIDTH=1 instance: 1+1.
    @(negedge clk);
    a1 = 1'b1; b1 = 1'b1; start1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start1 = 1'b0;
    lat1 = -1; dn = 0;
    for (int k = 0; k <= 5; k++) begin
      if (done1) begin
        dn++;
        if (lat1 < 0) begin
          lat1 = k;
          chk("w1_sum", int'(sum1), 0);
          chk("w1_carry", int'(carry1), 1);
        end
      end
      if (k < 5) @(negedge clk);
    end
    chk("w1_latency", lat1, 1);
    chk("w1_done_pulses", dn, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
